tmc_uart_phy: RTL and testbench

- Byte-level 8N1 UART engine that sits directly under the TMC UART command sequencer. The sequencer drives it byte by byte.
- Serializes bytes from the sequencer onto the shared single-wire bus and deserializes slave reply bytes back to it.
- Uses a fixed 4x oversampled bit clock.
- Handles start/stop framing, line synchronization and framing-error detection. Channel muxing and line-direction control stay in the sequencer.

---
 rtl/tmc_uart_pkg.sv | 14 +
 rtl/tmc_uart_phy_rx.sv | 121 ++++++++++++
 rtl/tmc_uart_phy.sv | 106 ++++++++++
 tb/tb_tmc_uart_phy.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmc_uart_pkg.sv
// tmc_uart_pkg: shared FSM states, framing constants and helpers for tmc_uart_phy.
package tmc_uart_pkg;
    localparam int TICKS_PER_BIT  = 4;
    localparam int DATA_BITS      = 8;
    localparam int SAMPLE_QUARTER = 2;
    localparam int RECOVER_TICKS  = 4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_RECOVER} rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/tmc_uart_phy_rx.sv
// tmc_uart_phy_rx: rx synchronizer and 8N1 receive FSM driven by quarter-bit ticks.
// TMC_UART_PHY_MAJORITY_EN selects 2-of-3 majority sampling at quarters 1..3.
module tmc_uart_phy_rx
    import tmc_uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       tick,
    output logic       div_restart,
    output logic [7:0] rx_byte,
    output logic       received,
    output logic       is_receiving,
    output logic       recv_error
);
    rx_state_e  state_q, state_d;
    logic [2:0] sync_q, sync_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d, rec_q, rec_d;
    logic [7:0] sr_q, sr_d, byte_q, byte_d;
    logic       rcvd_q, rcvd_d, err_q, err_d, busy_q, busy_d;
    logic       rx_s, rx_prev, sample_en, bit_val;

    assign sync_d  = {sync_q[1:0], rx};
    assign rx_s    = sync_q[1];
    assign rx_prev = sync_q[2];

`ifdef TMC_UART_PHY_MAJORITY_EN
    logic [1:0] maj_q, maj_d;
    assign sample_en = tick && qtr_q == 2'(SAMPLE_QUARTER);
    assign bit_val   = maj3(maj_q[0], maj_q[1], rx_s);
    always_comb begin
        maj_d = maj_q;
        if (tick && qtr_q == 2'(SAMPLE_QUARTER - 2)) maj_d[0] = rx_s;
        if (tick && qtr_q == 2'(SAMPLE_QUARTER - 1)) maj_d[1] = rx_s;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) maj_q <= 2'b11;
        else        maj_q <= maj_d;
`else
    assign sample_en = tick && qtr_q == 2'(SAMPLE_QUARTER - 1);
    assign bit_val   = rx_s;
`endif

    always_comb begin
        state_d     = state_q;
        qtr_d       = tick ? qtr_q + 2'd1 : qtr_q;
        bit_d       = bit_q;
        rec_d       = rec_q;
        sr_d        = sr_q;
        byte_d      = byte_q;
        busy_d      = busy_q;
        rcvd_d      = 1'b0;
        err_d       = 1'b0;
        div_restart = 1'b0;
        case (state_q)
            RX_IDLE: if (rx_prev && !rx_s) begin
                state_d     = RX_START;
                busy_d      = 1'b1;
                qtr_d       = '0;
                div_restart = 1'b1;
            end
            RX_START: if (sample_en) begin
                state_d = bit_val ? RX_IDLE : RX_DATA;
                busy_d  = !bit_val;
                err_d   = bit_val;
                bit_d   = '0;
            end
            RX_DATA: if (sample_en) begin
                sr_d    = {bit_val, sr_q[7:1]};
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'(DATA_BITS - 1) ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (sample_en) begin
                state_d = bit_val ? RX_IDLE : RX_RECOVER;
                byte_d  = bit_val ? sr_q : byte_q;
                rcvd_d  = bit_val;
                err_d   = !bit_val;
                busy_d  = 1'b0;
                rec_d   = '0;
            end
            // Stay here until the line has idled high long enough to rule out a break.
            RX_RECOVER: begin
                rec_d = !rx_s ? '0 : tick ? rec_q + 3'd1 : rec_q;
                if (rx_s && tick && rec_q == 3'(RECOVER_TICKS - 1)) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            sync_q  <= 3'b111;
            qtr_q   <= '0;
            bit_q   <= '0;
            rec_q   <= '0;
            sr_q    <= '0;
            byte_q  <= '0;
            rcvd_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            rec_q   <= rec_d;
            sr_q    <= sr_d;
            byte_q  <= byte_d;
            rcvd_q  <= rcvd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_byte      = byte_q;
    assign received     = rcvd_q;
    assign recv_error   = err_q;
    assign is_receiving = busy_q;
endmodule

// File: rtl/tmc_uart_phy.sv
// tmc_uart_phy: byte-level 8N1 UART engine with a 4x oversampled bit clock.
// Define TMC_UART_PHY_MAJORITY_EN for 2-of-3 majority sampling on the receiver.
module tmc_uart_phy
    import tmc_uart_pkg::*;
#(
    parameter int CLOCK_DIVIDE = 48,
    parameter int DIV_BITS     = $clog2(CLOCK_DIVIDE)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       is_transmitting,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       recv_error
);
    tx_state_e           tx_state_q, tx_state_d;
    logic [DIV_BITS-1:0] tx_div_q, tx_div_d, rx_div_q, rx_div_d;
    logic [1:0]          tx_qtr_q, tx_qtr_d;
    logic [2:0]          tx_bit_q, tx_bit_d;
    logic [7:0]          tx_shift_q, tx_shift_d;
    logic                tx_q, tx_d, busy_q, busy_d;
    logic                tx_tick, bit_end, rx_tick, rx_restart;

    assign tx_tick  = tx_div_q == DIV_BITS'(CLOCK_DIVIDE - 1);
    assign rx_tick  = rx_div_q == DIV_BITS'(CLOCK_DIVIDE - 1);
    assign bit_end  = tx_tick && tx_qtr_q == 2'(TICKS_PER_BIT - 1);
    assign rx_div_d = (rx_tick || rx_restart) ? '0 : rx_div_q + DIV_BITS'(1);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_tick ? '0 : tx_div_q + DIV_BITS'(1);
        tx_qtr_d   = tx_tick ? tx_qtr_q + 2'd1 : tx_qtr_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        case (tx_state_q)
            // Restarting the divider here makes the start bit a full bit long.
            TX_IDLE: if (transmit) begin
                tx_state_d = TX_START;
                tx_shift_d = tx_byte;
                tx_d       = 1'b0;
                busy_d     = 1'b1;
                tx_div_d   = '0;
                tx_qtr_d   = '0;
            end
            TX_START: if (bit_end) begin
                tx_state_d = TX_DATA;
                tx_d       = tx_shift_q[0];
                tx_bit_d   = '0;
            end
            TX_DATA: if (bit_end) begin
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_state_d = tx_bit_q == 3'(DATA_BITS - 1) ? TX_STOP : TX_DATA;
                tx_d       = tx_bit_q == 3'(DATA_BITS - 1) ? 1'b1 : tx_shift_q[1];
            end
            TX_STOP: if (bit_end) begin
                tx_state_d = TX_IDLE;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_div_q   <= '0;
            rx_div_q   <= '0;
            tx_qtr_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            rx_div_q   <= rx_div_d;
            tx_qtr_q   <= tx_qtr_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx              = tx_q;
    assign is_transmitting = busy_q;

    tmc_uart_phy_rx u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .tick         (rx_tick),
        .div_restart  (rx_restart),
        .rx_byte      (rx_byte),
        .received     (received),
        .is_receiving (is_receiving),
        .recv_error   (recv_error)
    );
endmodule

// File: tb/tb_tmc_uart_phy.sv
// tb_tmc_uart_phy: randomized self-checking bench for tmc_uart_phy at 16 cycles per bit.
module tb_tmc_uart_phy;
    localparam int CD  = 4;
    localparam int BIT = 4 * CD;

    logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, transmit = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx, is_transmitting, received, is_receiving, recv_error;
    logic [7:0] rx_byte;
    int         n_pass = 0, n_total = 0;
    int         err_cnt = 0, both_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] last_byte = 8'h00;

    tmc_uart_phy #(.CLOCK_DIVIDE(CD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx              (rx),
        .tx              (tx),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting),
        .received        (received),
        .rx_byte         (rx_byte),
        .is_receiving    (is_receiving),
        .recv_error      (recv_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (received) got_q.push_back(rx_byte);
            if (recv_error) err_cnt++;
            if (received && recv_error) both_cnt++;
        end
    end

    // Line level of a frame at bit slot idx: start, 8 data bits LSB first, stop, then idle.
    function automatic logic line_level(input logic [7:0] b, input int idx);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return idx > 9 ? 1'b1 : f[idx];
    endfunction

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_data(input logic [7:0] b);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_data(b);
        hold(1'b1, BIT);
    endtask

    task automatic tx_frame(input logic [7:0] b, input bit poke);
        logic exp_tx;
        transmit = 1'b1;
        tx_byte  = b;
        @(posedge clk);
        #1;
        transmit = 1'b0;
        tx_byte  = 8'($urandom);
        for (int k = 1; k <= 161; k++) begin
            @(negedge clk);
            exp_tx = line_level(b, (k - 1) / BIT);
            n_total++;
            if (tx !== exp_tx) $display("FAIL tx_wave byte=%02h k=%0d got %b want %b", b, k, tx, exp_tx);
            else n_pass++;
            n_total++;
            if (is_transmitting !== (k <= 160)) $display("FAIL tx_busy byte=%02h k=%0d got %b want %b", b, k, is_transmitting, k <= 160);
            else n_pass++;
            if (poke && k == 20) begin
                transmit = 1'b1;
                tx_byte  = ~b;
            end
            if (poke && k == 21) transmit = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx);
        else n_pass++;
        n_total++;
        if ({is_transmitting, received, recv_error, is_receiving} !== 4'b0000)
            $display("FAIL reset_strobes got %b want 0000", {is_transmitting, received, recv_error, is_receiving});
        else n_pass++;
        n_total++;
        if (rx_byte !== 8'h00) $display("FAIL reset_rx_byte got %02h want 00", rx_byte);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_tx;
        repeat (2) @(posedge clk);
        #1;
        tx_frame(8'hA5, 1'b0);
        repeat (3) tx_frame(8'($urandom), 1'b0);
    endtask

    task automatic test_tx_ignore;
        tx_frame(8'($urandom), 1'b1);
        tx_frame(8'h3C, 1'b1);
    endtask

    task automatic test_reset_mid_tx;
        transmit = 1'b1;
        tx_byte  = 8'h00;
        @(posedge clk);
        #1;
        transmit = 1'b0;
        repeat (3 * BIT + 8) @(posedge clk);
        #1;
        n_total++;
        if ({tx, is_transmitting} !== 2'b01) $display("FAIL midtx_before got %b want 01", {tx, is_transmitting});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({tx, is_transmitting} !== 2'b10) $display("FAIL midtx_reset got %b want 10", {tx, is_transmitting});
        else n_pass++;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (BIT) @(posedge clk);
        #1;
        n_total++;
        if ({tx, is_transmitting} !== 2'b10) $display("FAIL midtx_after got %b want 10", {tx, is_transmitting});
        else n_pass++;
        last_byte = 8'h00;
    endtask

    task automatic test_rx_basic;
        logic [7:0] b;
        b = 8'h05;
        got_q.delete();
        err_cnt = 0;
        hold(1'b0, BIT);
        for (int i = 0; i < 3; i++) hold(b[i], BIT);
        hold(b[3], BIT / 2);
        n_total++;
        if (is_receiving !== 1'b1) $display("FAIL rx_busy_mid got %b want 1", is_receiving);
        else n_pass++;
        hold(b[3], BIT / 2);
        for (int i = 4; i < 8; i++) hold(b[i], BIT);
        hold(1'b1, 3 * BIT);
        n_total++;
        if (got_q.size() != 1) $display("FAIL rx_basic_count got %0d want 1", got_q.size());
        else n_pass++;
        n_total++;
        if (got_q.size() < 1 || got_q[0] !== b) $display("FAIL rx_basic_value got %02h want %02h", rx_byte, b);
        else n_pass++;
        n_total++;
        if ({err_cnt, is_receiving} !== {32'd0, 1'b0}) $display("FAIL rx_basic_idle got err=%0d busy=%b want 0 0", err_cnt, is_receiving);
        else n_pass++;
        last_byte = b;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        exp_q = '{8'hFF, 8'h13};
        repeat (4) exp_q.push_back(8'($urandom));
        got_q.delete();
        err_cnt = 0;
        foreach (exp_q[i]) begin
            send_frame(exp_q[i]);
            hold(1'b1, BIT);
        end
        hold(1'b1, BIT);
        n_total++;
        if (got_q.size() != exp_q.size()) $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        foreach (exp_q[i]) begin
            n_total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i])
                $display("FAIL b2b_value idx=%0d got %02h want %02h", i, i < got_q.size() ? got_q[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (err_cnt != 0) $display("FAIL b2b_errors got %0d want 0", err_cnt);
        else n_pass++;
        last_byte = exp_q[exp_q.size() - 1];
    endtask

    task automatic test_glitch;
        got_q.delete();
        err_cnt = 0;
        hold(1'b0, 6);
        hold(1'b1, 3 * BIT);
        n_total++;
        if (err_cnt != 1) $display("FAIL glitch_error got %0d want 1", err_cnt);
        else n_pass++;
        n_total++;
        if (got_q.size() != 0 || is_receiving !== 1'b0) $display("FAIL glitch_quiet got rcv=%0d busy=%b want 0 0", got_q.size(), is_receiving);
        else n_pass++;
        send_frame(8'h3C);
        hold(1'b1, 2 * BIT);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== 8'h3C) $display("FAIL glitch_next got n=%0d byte=%02h want 1 3c", got_q.size(), rx_byte);
        else n_pass++;
        last_byte = 8'h3C;
    endtask

    task automatic test_framing;
        got_q.delete();
        err_cnt = 0;
        send_data(8'h81);
        hold(1'b0, 3 * BIT);
        hold(1'b1, 8);
        hold(1'b0, 8);
        hold(1'b1, 2 * BIT);
        n_total++;
        if (err_cnt != 1) $display("FAIL framing_error got %0d want 1", err_cnt);
        else n_pass++;
        n_total++;
        if (got_q.size() != 0 || rx_byte !== last_byte) $display("FAIL framing_hold got n=%0d byte=%02h want 0 %02h", got_q.size(), rx_byte, last_byte);
        else n_pass++;
        send_frame(8'h42);
        hold(1'b1, 2 * BIT);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== 8'h42 || err_cnt != 1)
            $display("FAIL framing_next got n=%0d byte=%02h err=%0d want 1 42 1", got_q.size(), rx_byte, err_cnt);
        else n_pass++;
        last_byte = 8'h42;
    endtask

`ifdef TMC_UART_PHY_MAJORITY_EN
    task automatic test_majority;
        got_q.delete();
        err_cnt = 0;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(1'b0, BIT);
        hold(1'b0, BIT / 2);
        hold(1'b1, BIT / 4);
        hold(1'b0, BIT / 4);
        for (int i = 5; i < 8; i++) hold(1'b0, BIT);
        hold(1'b1, 3 * BIT);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== 8'h00 || err_cnt != 0)
            $display("FAIL majority got n=%0d byte=%02h err=%0d want 1 00 0", got_q.size(), rx_byte, err_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset;
        test_tx;
        test_tx_ignore;
        test_reset_mid_tx;
        test_rx_basic;
        test_back_to_back;
        test_glitch;
        test_framing;
`ifdef TMC_UART_PHY_MAJORITY_EN
        test_majority;
`endif
        n_total++;
        if (both_cnt != 0) $display("FAIL strobe_overlap got %0d want 0", both_cnt);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
